// File: rtl/coh_arb_pkg.sv
// ---------------------------------------------------------------------------
// coh_arb_pkg
// Shared types and constants for the coherence request arbiter.
//   arb_state_t   : arbiter FSM states
//   ERR_RESP_BIT  : fill bit for the data returned on a timed-out response
// ---------------------------------------------------------------------------
package coh_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_RESP = 3'd2,
        DELIVER   = 3'd3,
        DRAIN     = 3'd4
    } arb_state_t;

    // Error responses carry all-zero data; replicate this bit to DATA_WIDTH.
    localparam logic ERR_RESP_BIT = 1'b0;

endpackage

// File: rtl/coh_arb_rr_picker.sv
// ---------------------------------------------------------------------------
// coh_arb_rr_picker
// Combinational rotating-priority picker. Scans candidates upward starting
// at ptr+1 (wrapping modulo N) and returns the first hit.
//   valid     in  N      request vector
//   ptr       in  IDX_W  index of the last round-robin grant
//   exclude   in  N      requesters removed from the scan
//   grant     out N      one-hot grant (zero if nothing eligible)
//   grant_idx out IDX_W  index of the grant (0 if none)
//   found     out 1      an eligible requester exists
// ---------------------------------------------------------------------------
module coh_arb_rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] ptr,
    input  logic [N-1:0]     exclude,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             found
);

    logic [N-1:0]     cand_s;
    logic [IDX_W-1:0] idx_s;
    logic             hit_s;

    assign cand_s = valid & ~exclude;

    // Branch-free first-hit scan starting just past the pointer.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s            = IDX_W'((int'(ptr) + k) % N);
            hit_s            = !found && cand_s[idx_s];
            grant[idx_s]     = grant[idx_s] | hit_s;
            grant_idx        = hit_s ? idx_s : grant_idx;
            found            = found | hit_s;
        end
    end

endmodule

// File: rtl/coherence_req_arbiter.sv
// ---------------------------------------------------------------------------
// coherence_req_arbiter
// Shares the single-outstanding directory request port among NUM_REQ
// requesters: strict priority for PRIO_REQ (capped by STARVE_LIMIT while
// others wait), round-robin among the rest. One transaction in flight; the
// response goes back to the issuing requester only. A response timeout
// returns an error and the late response is drained before the next issue.
// Ports: req_* (requester side, packed per requester), resp_* (response
// back to requesters), dir_req_* / dir_resp_* (directory side), busy,
// grant_id, grant_count, timeout_count (statistics).
// Optional: define COH_ARB_STATS_EN to build the grant/timeout counters;
// otherwise grant_count and timeout_count are tied to zero.
// ---------------------------------------------------------------------------
module coherence_req_arbiter
    import coh_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_WIDTH     = 64,
    parameter int DATA_WIDTH     = 512,
    parameter int PRIO_REQ       = 0,
    parameter int STARVE_LIMIT   = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_data,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]                resp_valid,
    input  logic [NUM_REQ-1:0]                resp_ready,
    output logic [DATA_WIDTH-1:0]             resp_data,
    output logic                              resp_error,
    output logic                              dir_req_valid,
    input  logic                              dir_req_ready,
    output logic                              dir_req_write,
    output logic [ADDR_WIDTH-1:0]             dir_req_addr,
    output logic [DATA_WIDTH-1:0]             dir_req_data,
    output logic [DATA_WIDTH/8-1:0]           dir_req_strb,
    input  logic                              dir_resp_valid,
    output logic                              dir_resp_ready,
    input  logic [DATA_WIDTH-1:0]             dir_resp_data,
    input  logic                              dir_resp_error,
    output logic                              busy,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic [NUM_REQ*32-1:0]             grant_count,
    output logic [31:0]                       timeout_count
);

    localparam int IDX_W  = $clog2(NUM_REQ);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int RUN_W  = $clog2(STARVE_LIMIT + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);

    arb_state_t          state_r, state_nxt_s;
    logic [IDX_W-1:0]    grant_id_r, rr_ptr_r;
    logic [RUN_W-1:0]    prio_run_r;
    logic [TMR_W-1:0]    timer_r;
    logic                drain_pending_r;
    logic                write_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [DATA_WIDTH-1:0] data_r, resp_data_r;
    logic [STRB_W-1:0]   strb_r;
    logic                resp_error_r;

    logic [NUM_REQ-1:0]  prio_mask_s, rr_grant_s, pick_oh_s;
    logic [IDX_W-1:0]    rr_idx_s, pick_idx_s;
    logic                rr_found_s, others_valid_s, prio_ok_s;
    logic                req_fire_s, timeout_s;

    assign prio_mask_s    = NUM_REQ'(1) << PRIO_REQ;
    assign others_valid_s = |(req_valid & ~prio_mask_s);
    // Demand wins unless it has used up its run while someone else waits.
    assign prio_ok_s      = req_valid[PRIO_REQ] &&
                            ((prio_run_r < RUN_W'(STARVE_LIMIT)) || !others_valid_s);

    coh_arb_rr_picker #(.N(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .valid     (req_valid),
        .ptr       (rr_ptr_r),
        .exclude   (prio_mask_s),
        .grant     (rr_grant_s),
        .grant_idx (rr_idx_s),
        .found     (rr_found_s)
    );

    // Select the requester to offer req_ready to in IDLE.
    always_comb begin
        pick_oh_s  = '0;
        pick_idx_s = '0;
        if (prio_ok_s) begin
            pick_oh_s  = prio_mask_s;
            pick_idx_s = IDX_W'(PRIO_REQ);
        end else if (rr_found_s) begin
            pick_oh_s  = rr_grant_s;
            pick_idx_s = rr_idx_s;
        end else begin
            pick_oh_s  = '0;
            pick_idx_s = '0;
        end
    end

    assign req_ready  = (state_r == IDLE) ? pick_oh_s : '0;
    assign req_fire_s = |(req_valid & req_ready);
    // A response on the timeout cycle takes precedence over the error.
    assign timeout_s  = (state_r == WAIT_RESP) && !dir_resp_valid &&
                        (timer_r == TMR_W'(TIMEOUT_CYCLES - 1));

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_nxt_s    = state_r;
        dir_req_valid  = 1'b0;
        dir_resp_ready = 1'b0;
        resp_valid     = '0;
        case (state_r)
            IDLE: begin
                if (req_fire_s) state_nxt_s = ISSUE;
                else            state_nxt_s = IDLE;
            end
            ISSUE: begin
                dir_req_valid = 1'b1;
                if (dir_req_ready) state_nxt_s = WAIT_RESP;
                else               state_nxt_s = ISSUE;
            end
            WAIT_RESP: begin
                dir_resp_ready = 1'b1;
                if (dir_resp_valid || timeout_s) state_nxt_s = DELIVER;
                else                             state_nxt_s = WAIT_RESP;
            end
            DELIVER: begin
                resp_valid     = NUM_REQ'(1) << grant_id_r;
                dir_resp_ready = drain_pending_r;
                if (resp_ready[grant_id_r]) begin
                    // A late response absorbed this cycle makes DRAIN unnecessary.
                    if (drain_pending_r && !dir_resp_valid) state_nxt_s = DRAIN;
                    else                                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DELIVER;
                end
            end
            DRAIN: begin
                dir_resp_ready = 1'b1;
                if (dir_resp_valid) state_nxt_s = IDLE;
                else                state_nxt_s = DRAIN;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Transaction datapath: payload latch, fairness state, timer, response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id_r      <= '0;
            rr_ptr_r        <= '0;
            prio_run_r      <= '0;
            timer_r         <= '0;
            drain_pending_r <= 1'b0;
            write_r         <= 1'b0;
            addr_r          <= '0;
            data_r          <= '0;
            strb_r          <= '0;
            resp_data_r     <= '0;
            resp_error_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_fire_s) begin
                        grant_id_r <= pick_idx_s;
                        write_r    <= req_write[pick_idx_s];
                        addr_r     <= req_addr[int'(pick_idx_s)*ADDR_WIDTH +: ADDR_WIDTH];
                        data_r     <= req_data[int'(pick_idx_s)*DATA_WIDTH +: DATA_WIDTH];
                        strb_r     <= req_strb[int'(pick_idx_s)*STRB_W +: STRB_W];
                        timer_r    <= '0;
                        if (pick_idx_s == IDX_W'(PRIO_REQ)) begin
                            if (prio_run_r != RUN_W'(STARVE_LIMIT))
                                prio_run_r <= prio_run_r + RUN_W'(1);
                        end else begin
                            prio_run_r <= '0;
                            rr_ptr_r   <= pick_idx_s;
                        end
                    end
                end
                WAIT_RESP: begin
                    timer_r <= timer_r + TMR_W'(1);
                    if (dir_resp_valid) begin
                        resp_data_r     <= dir_resp_data;
                        resp_error_r    <= dir_resp_error;
                        drain_pending_r <= 1'b0;
                    end else if (timeout_s) begin
                        resp_data_r     <= {DATA_WIDTH{ERR_RESP_BIT}};
                        resp_error_r    <= 1'b1;
                        drain_pending_r <= 1'b1;
                    end
                end
                DELIVER: begin
                    if (drain_pending_r && dir_resp_valid)
                        drain_pending_r <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign dir_req_write = write_r;
    assign dir_req_addr  = addr_r;
    assign dir_req_data  = data_r;
    assign dir_req_strb  = strb_r;
    assign resp_data     = resp_data_r;
    assign resp_error    = resp_error_r;
    assign busy          = (state_r != IDLE);
    assign grant_id      = grant_id_r;

`ifdef COH_ARB_STATS_EN
    logic [31:0] grant_cnt_r [NUM_REQ];
    logic [31:0] timeout_cnt_r;

    // Wrapping per-requester grant counters and timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) grant_cnt_r[i] <= 32'd0;
            timeout_cnt_r <= 32'd0;
        end else begin
            if (req_fire_s) grant_cnt_r[pick_idx_s] <= grant_cnt_r[pick_idx_s] + 32'd1;
            if (timeout_s)  timeout_cnt_r <= timeout_cnt_r + 32'd1;
        end
    end

    // Pack counters onto the flat statistics port.
    always_comb begin
        grant_count = '0;
        for (int i = 0; i < NUM_REQ; i++) grant_count[i*32 +: 32] = grant_cnt_r[i];
    end
    assign timeout_count = timeout_cnt_r;
`else
    assign grant_count   = '0;
    assign timeout_count = 32'd0;
`endif

endmodule

// File: tb/tb_coherence_req_arbiter.sv
module tb_coherence_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 512;
    localparam int SW = DW / 8;

    logic              clk, rst_n;
    logic [N-1:0]      req_valid, req_ready, req_write, resp_valid, resp_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_data;
    logic [N*SW-1:0]   req_strb;
    logic [DW-1:0]     resp_data, dir_req_data, dir_resp_data;
    logic              resp_error, dir_req_valid, dir_req_ready, dir_req_write;
    logic [AW-1:0]     dir_req_addr;
    logic [SW-1:0]     dir_req_strb;
    logic              dir_resp_valid, dir_resp_ready, dir_resp_error, busy;
    logic [1:0]        grant_id;
    logic [N*32-1:0]   grant_count;
    logic [31:0]       timeout_count;

    coherence_req_arbiter #(
        .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PRIO_REQ(0),
        .STARVE_LIMIT(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_error(resp_error),
        .dir_req_valid(dir_req_valid), .dir_req_ready(dir_req_ready),
        .dir_req_write(dir_req_write), .dir_req_addr(dir_req_addr),
        .dir_req_data(dir_req_data), .dir_req_strb(dir_req_strb),
        .dir_resp_valid(dir_resp_valid), .dir_resp_ready(dir_resp_ready),
        .dir_resp_data(dir_resp_data), .dir_resp_error(dir_resp_error),
        .busy(busy), .grant_id(grant_id),
        .grant_count(grant_count), .timeout_count(timeout_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests;
    int fails;

    typedef struct {
        logic [N-1:0] mask;
        int           exp_gid;
        bit           rst_before;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] addr_of(input int i);
        return 64'h0800 + 64'(i) * 64'h0400;
    endfunction

    task automatic set_default_payload();
        req_write = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = addr_of(i);
            req_data[i*DW +: DW] = '0;
            req_strb[i*SW +: SW] = '0;
        end
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        req_valid      = '0;
        resp_ready     = '0;
        dir_req_ready  = 1'b0;
        dir_resp_valid = 1'b0;
        dir_resp_error = 1'b0;
        dir_resp_data  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    function automatic logic outs_zero();
        return !(busy | dir_req_valid | dir_resp_ready | (|resp_valid) | (|req_ready) |
                 resp_error | (|resp_data) | (|grant_id) | dir_req_write | (|dir_req_addr) |
                 (|dir_req_data) | (|dir_req_strb) | (|grant_count) | (|timeout_count));
    endfunction

    // One full read transaction; called and returns at a negedge.
    task automatic run_txn(input logic [N-1:0] mask, input int delay,
                           input logic [DW-1:0] rdata, output int gid);
        int c;
        gid = -1;
        req_valid = mask;
        #1;
        c = 0;
        while (req_ready == '0 && c < 20) begin
            @(negedge clk); #1; c++;
        end
        if (req_ready == '0) begin
            check("grant_wait", 512'(req_ready), 512'(mask));
            return;
        end
        check("ready_onehot", 512'($onehot(req_ready)), 512'(1));
        for (int i = 0; i < N; i++) if (req_ready[i]) gid = i;
        @(posedge clk);
        @(negedge clk);
        check("issue_latency", 512'(dir_req_valid), 512'(1));
        check("dir_addr", 512'(dir_req_addr), 512'(addr_of(gid)));
        dir_req_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dir_req_ready = 1'b0;
        repeat (delay) @(negedge clk);
        dir_resp_valid = 1'b1;
        dir_resp_error = 1'b0;
        dir_resp_data  = rdata;
        @(negedge clk);
        dir_resp_valid = 1'b0;
        check("resp_valid", 512'(resp_valid), 512'(4'b0001 << gid));
        check("resp_data", resp_data, rdata);
        check("resp_error", 512'(resp_error), 512'(0));
        resp_ready = resp_valid;
        @(negedge clk);
        resp_ready = '0;
    endtask

    initial begin
        int gid;
        int n;
        int xfers;
        logic ok;
        tests = 0;
        fails = 0;
        set_default_payload();

        // Reset state
        rst_n = 1'b0; req_valid = '0; resp_ready = '0; dir_req_ready = 1'b0;
        dir_resp_valid = 1'b0; dir_resp_error = 1'b0; dir_resp_data = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", 512'(outs_zero()), 512'(1));
        rst_n = 1'b1;
        @(negedge clk);

        // Single read from requester 2
        run_txn(4'b0100, 5, {8{64'hA5A5_A5A5_A5A5_A5A5}}, gid);
        check("t1_gid", 512'(gid), 512'(2));
        check("t1_grant_id", 512'(grant_id), 512'(2));
        check("t1_idle", 512'(busy), 512'(0));

        // Table: round-robin order, then starvation cap
        vecs[0] = '{4'b1110, 1, 1'b1};
        vecs[1] = '{4'b1110, 2, 1'b0};
        vecs[2] = '{4'b1110, 3, 1'b0};
        vecs[3] = '{4'b1110, 1, 1'b0};
        vecs[4] = '{4'b1110, 2, 1'b0};
        vecs[5] = '{4'b1110, 3, 1'b0};
        vecs[6] = '{4'b0011, 0, 1'b1};
        for (int k = 7; k < 14; k++) vecs[k] = '{4'b0011, 0, 1'b0};
        vecs[14] = '{4'b0011, 1, 1'b0};
        vecs[15] = '{4'b0011, 0, 1'b0};
        for (int k = 0; k < 16; k++) begin
            if (vecs[k].rst_before) do_reset();
            run_txn(vecs[k].mask, k % 3, {16{32'h5A5A_0000 + 32'(k)}}, gid);
            check($sformatf("vec%0d_gid", k), 512'(gid), 512'(vecs[k].exp_gid));
        end
        req_valid = '0;

        // Timeout with late response drained
        do_reset();
        req_valid = 4'b0010;
        #1;
        check("to_ready", 512'(req_ready), 512'(4'b0010));
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        dir_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dir_req_ready = 1'b0;
        n = 0;
        while (resp_valid == '0 && n < 100) begin
            n++; @(negedge clk);
        end
        check("to_wait_cycles", 512'(n), 512'(16));
        check("to_resp_valid", 512'(resp_valid), 512'(4'b0010));
        check("to_resp_error", 512'(resp_error), 512'(1));
        check("to_resp_data", resp_data, '0);
        check("to_dir_resp_ready", 512'(dir_resp_ready), 512'(1));
        resp_ready = resp_valid;
        @(negedge clk);
        resp_ready = '0;
        req_valid = 4'b0100;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (req_ready != '0 || !busy || !dir_resp_ready) ok = 1'b0;
            @(negedge clk);
        end
        check("drain_blocks_req", 512'(ok), 512'(1));
        dir_resp_valid = 1'b1;
        dir_resp_data  = {16{32'hBAD0_BAD0}};
        @(negedge clk);
        dir_resp_valid = 1'b0;
        check("drain_done_ready", 512'(req_ready), 512'(4'b0100));
        run_txn(4'b0100, 2, {16{32'h1234_5678}}, gid);
        check("post_drain_gid", 512'(gid), 512'(2));
`ifdef COH_ARB_STATS_EN
        check("timeout_count", 512'(timeout_count), 512'(1));
`else
        check("timeout_count", 512'(timeout_count), 512'(0));
`endif
        req_valid = '0;

        // Write with dir_req_ready held low for 10 cycles
        do_reset();
        req_write[3] = 1'b1;
        req_addr[3*AW +: AW] = 64'h2000;
        req_data[3*DW +: DW] = {16{32'hDEAD_BEEF}};
        req_strb[3*SW +: SW] = 64'h00FF_00FF_F0F0_0F0F;
        req_valid = 4'b1000;
        #1;
        check("wr_ready", 512'(req_ready), 512'(4'b1000));
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        req_addr[3*AW +: AW] = 64'hFFFF;
        req_data[3*DW +: DW] = '0;
        req_strb[3*SW +: SW] = '0;
        req_write[3] = 1'b0;
        ok = 1'b1;
        xfers = 0;
        for (int c = 0; c < 10; c++) begin
            if (!dir_req_valid || !dir_req_write || dir_req_addr !== 64'h2000 ||
                dir_req_data !== {16{32'hDEAD_BEEF}} || dir_req_strb !== 64'h00FF_00FF_F0F0_0F0F)
                ok = 1'b0;
            if (dir_req_valid && dir_req_ready) xfers++;
            @(negedge clk);
        end
        check("wr_stable", 512'(ok), 512'(1));
        dir_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (dir_req_valid && dir_req_ready) xfers++;
            @(negedge clk);
        end
        dir_req_ready = 1'b0;
        check("wr_one_xfer", 512'(xfers), 512'(1));
        dir_resp_valid = 1'b1;
        dir_resp_data  = '0;
        @(negedge clk);
        dir_resp_valid = 1'b0;
        check("wr_resp_valid", 512'(resp_valid), 512'(4'b1000));
        resp_ready = resp_valid;
        @(negedge clk);
        resp_ready = '0;
        set_default_payload();

        // Reset asserted during WAIT_RESP
        req_valid = 4'b0100;
        #1;
        @(posedge clk); @(negedge clk);
        req_valid = '0;
        dir_req_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        dir_req_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_busy", 512'(busy && dir_resp_ready), 512'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_outputs", 512'(outs_zero()), 512'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(4'b1110, 1, {8{64'h0F0F_0F0F_0F0F_0F0F}}, gid);
        check("rst_rr_ptr_gid", 512'(gid), 512'(1));
        req_valid = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
